// File: rtl/hamming_host_pkg.sv
// rtl/hamming_host_pkg.sv - shared states and constants for the Hamming core host initiator
package hamming_host_pkg;

  typedef enum logic [3:0] {
    S_FLUSH = 4'd0,
    S_IDLE  = 4'd1,
    S_START = 4'd2,
    S_MODE  = 4'd3,
    S_DATA  = 4'd4,
    S_WAIT  = 4'd5,
    S_CAP0  = 4'd6,
    S_CAP1  = 4'd7,
    S_RESP  = 4'd8
  } state_t;

  localparam logic [7:0] PIN_START = 8'h01;
  localparam logic       MODE_ENC  = 1'b0;
  localparam logic       MODE_DEC  = 1'b1;
  localparam int         FLUSH_CYC = 5;
  localparam int         SYN_LSB   = 2;
  localparam int         ERR_LSB   = 0;

endpackage

// File: rtl/hamming_host_ctrl.sv
// rtl/hamming_host_ctrl.sv - serialises one encode/decode request onto the core pins and captures its two result bytes
// Optional protocol check of the returned bytes: HAMMING_HOST_CHECK_EN
module hamming_host_ctrl
  import hamming_host_pkg::*;
#(
  parameter int EXTRA_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_mode,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_byte0,
  output logic [7:0] rsp_byte1,
  output logic [2:0] rsp_syndrome,
  output logic [1:0] rsp_err,
  output logic       rsp_proto_err,
  output logic [7:0] pin_out,
  input  logic [7:0] pin_in,
  output logic       busy
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC + EXTRA_LAT);
  localparam logic [3:0] WAIT_LOAD  = 4'(EXTRA_LAT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [7:0] w_pin;
  logic       r_mode;
  logic [7:0] r_data;
  logic [7:0] r_byte0;
  logic [7:0] r_byte1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FLUSH;
      r_cnt   <= FLUSH_LOAD;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Flush counts remaining cycles including the current one, so FLUSH_LOAD cycles are spent there
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pin       = 8'h00;
    case (r_state)
      S_FLUSH: begin
        if (r_cnt <= 4'd1) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_IDLE: begin
        if (req_valid) w_state_nxt = S_START;
      end
      S_START: begin
        w_pin       = PIN_START;
        w_state_nxt = S_MODE;
      end
      S_MODE: begin
        w_pin       = {7'b0, r_mode};
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_pin       = (r_mode == MODE_DEC) ? r_data : {4'b0, r_data[3:0]};
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = WAIT_LOAD;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_CAP0;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_CAP0: w_state_nxt = S_CAP1;
      S_CAP1: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_FLUSH;
        w_cnt_nxt   = FLUSH_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= MODE_DEC;
      r_data  <= 8'h00;
      r_byte0 <= 8'h00;
      r_byte1 <= 8'h00;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_mode <= req_mode;
        r_data <= req_data;
      end
      if (r_state == S_CAP0) r_byte0 <= pin_in;
      if (r_state == S_CAP1) r_byte1 <= pin_in;
    end
  end

`ifdef HAMMING_HOST_CHECK_EN
  logic r_proto_err;
  logic w_proto_err;

  // The core repeats the codeword on encode; decode leaves the top three bits of byte1 clear
  assign w_proto_err = (r_mode == MODE_ENC) ? (pin_in != r_byte0) : (pin_in[7:5] != 3'b000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_proto_err <= 1'b0;
    else if (r_state == S_CAP1) r_proto_err <= w_proto_err;
  end

  assign rsp_proto_err = r_proto_err;
`else
  assign rsp_proto_err = 1'b0;
`endif

  assign pin_out      = w_pin;
  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_RESP);
  assign busy         = (r_state != S_IDLE);
  assign rsp_byte0    = r_byte0;
  assign rsp_byte1    = r_byte1;
  assign rsp_syndrome = (r_mode == MODE_DEC) ? r_byte1[SYN_LSB +: 3] : 3'b000;
  assign rsp_err      = (r_mode == MODE_DEC) ? r_byte1[ERR_LSB +: 2] : 2'b00;

endmodule

// File: tb/tb_hamming_host_ctrl.sv
// tb/tb_hamming_host_ctrl.sv - directed bench for hamming_host_ctrl with two pin-level core models (EXTRA_LAT 0 and 3)
module tb_hamming_host_ctrl;

`ifdef HAMMING_HOST_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       req_valid = 1'b0, req_mode = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, rsp_valid, rsp_proto_err, busy;
  logic [7:0] rsp_byte0, rsp_byte1, pin_out, pin_in;
  logic [2:0] rsp_syndrome;
  logic [1:0] rsp_err;

  logic       x_req_valid = 1'b0, x_req_mode = 1'b0, x_rsp_ready = 1'b0;
  logic [7:0] x_req_data = 8'h00;
  logic       x_req_ready, x_rsp_valid, x_rsp_proto_err, x_busy;
  logic [7:0] x_rsp_byte0, x_rsp_byte1, x_pin_out, x_pin_in;
  logic [2:0] x_rsp_syndrome;
  logic [1:0] x_rsp_err;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         lat;
  logic [7:0] seq [0:15];

  always #5 clk = ~clk;

  hamming_host_ctrl #(.EXTRA_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_byte0(rsp_byte0), .rsp_byte1(rsp_byte1),
    .rsp_syndrome(rsp_syndrome), .rsp_err(rsp_err), .rsp_proto_err(rsp_proto_err),
    .pin_out(pin_out), .pin_in(pin_in), .busy(busy)
  );

  hamming_host_ctrl #(.EXTRA_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(x_req_valid), .req_ready(x_req_ready), .req_mode(x_req_mode), .req_data(x_req_data),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_byte0(x_rsp_byte0), .rsp_byte1(x_rsp_byte1),
    .rsp_syndrome(x_rsp_syndrome), .rsp_err(x_rsp_err), .rsp_proto_err(x_rsp_proto_err),
    .pin_out(x_pin_out), .pin_in(x_pin_in), .busy(x_busy)
  );

  // Core models: start seen, then mode, data, one compute cycle, then two result bytes (delayed by the pad latency)
  int         m0_step = 0;
  logic [7:0] m0_b0 = 8'h00, m0_b1 = 8'h00;
  always @(posedge clk) begin
    if (m0_step == 0) begin
      if (pin_out == 8'h01) m0_step <= 1;
    end else if (m0_step >= 5) m0_step <= 0;
    else m0_step <= m0_step + 1;
  end
  assign pin_in = (m0_step == 4) ? m0_b0 : (m0_step == 5) ? m0_b1 : 8'h00;

  int         m3_step = 0;
  logic [7:0] m3_b0 = 8'h00, m3_b1 = 8'h00;
  always @(posedge clk) begin
    if (m3_step == 0) begin
      if (x_pin_out == 8'h01) m3_step <= 1;
    end else if (m3_step >= 8) m3_step <= 0;
    else m3_step <= m3_step + 1;
  end
  assign x_pin_in = (m3_step == 7) ? m3_b0 : (m3_step == 8) ? m3_b1 : 8'h00;

  task automatic request0(input logic mode, input logic [7:0] data);
    int wait_n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_mode = mode; req_data = data;
    while (req_ready !== 1'b1 && wait_n < 30) begin @(negedge clk); wait_n++; end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL accept: req_ready=%b want 1", req_ready); end
    @(posedge clk);
    lat = 1;
    #1;
    req_valid = 1'b0; req_mode = ~mode; req_data = 8'hFF;
    seq[1] = pin_out;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); lat++; #1;
      if (lat < 16) seq[lat] = pin_out;
    end
  endtask

  task automatic complete0();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rsp_drop: rsp_valid=%b want 0", rsp_valid); end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: req_ready=%b want 1", req_ready); end
  endtask

  task automatic test_reset();
    int n = 0, first0 = 0, first3 = 0, pin_bad = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, busy, pin_out, rsp_byte0, rsp_byte1, rsp_proto_err} !== {3'b001, 24'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_vals: ready/valid/busy=%b%b%b pin=%h b0=%h b1=%h perr=%b want 001 00 00 00 0",
               req_ready, rsp_valid, busy, pin_out, rsp_byte0, rsp_byte1, rsp_proto_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    while ((first0 == 0 || first3 == 0) && n < 20) begin
      @(posedge clk); n++; #1;
      if (pin_out !== 8'h00 || x_pin_out !== 8'h00) pin_bad++;
      if (req_ready === 1'b1 && first0 == 0) first0 = n;
      if (x_req_ready === 1'b1 && first3 == 0) first3 = n;
    end
    n_cmp++;
    if (first0 !== 5) begin n_bad++; $display("FAIL flush_lat0: %0d cycles want 5", first0); end
    n_cmp++;
    if (first3 !== 8) begin n_bad++; $display("FAIL flush_lat3: %0d cycles want 8", first3); end
    n_cmp++;
    if (pin_bad !== 0) begin n_bad++; $display("FAIL flush_pins: %0d nonzero samples want 0", pin_bad); end
    n_cmp++;
    if ({busy, x_busy} !== 2'b00) begin n_bad++; $display("FAIL idle_busy: %b want 00", {busy, x_busy}); end
  endtask

  task automatic test_encode();
    m0_b0 = 8'h5A; m0_b1 = 8'h5A;
    request0(1'b0, 8'h0B);
    n_cmp++;
    if (lat !== 7) begin n_bad++; $display("FAIL enc_latency: %0d want 7", lat); end
    n_cmp++;
    if ({seq[1], seq[2], seq[3], seq[4]} !== 32'h01000B00) begin
      n_bad++; $display("FAIL enc_pins: %h want 01000b00", {seq[1], seq[2], seq[3], seq[4]});
    end
    n_cmp++;
    if ({rsp_byte0, rsp_byte1, rsp_syndrome, rsp_err, rsp_proto_err} !== {16'h5A5A, 3'b000, 2'b00, 1'b0}) begin
      n_bad++; $display("FAIL enc_rsp: b0=%h b1=%h syn=%b err=%b perr=%b want 5a 5a 000 00 0",
                        rsp_byte0, rsp_byte1, rsp_syndrome, rsp_err, rsp_proto_err);
    end
    complete0();
  endtask

  task automatic test_decode();
    m0_b0 = 8'h06; m0_b1 = 8'h0D;
    request0(1'b1, 8'hC7);
    n_cmp++;
    if (lat !== 7) begin n_bad++; $display("FAIL dec_latency: %0d want 7", lat); end
    n_cmp++;
    if ({seq[1], seq[2], seq[3], seq[4]} !== 32'h0101C700) begin
      n_bad++; $display("FAIL dec_pins: %h want 0101c700", {seq[1], seq[2], seq[3], seq[4]});
    end
    n_cmp++;
    if ({rsp_byte0, rsp_byte1} !== 16'h060D) begin
      n_bad++; $display("FAIL dec_bytes: %h want 060d", {rsp_byte0, rsp_byte1});
    end
    n_cmp++;
    if ({rsp_syndrome, rsp_err, rsp_proto_err} !== 6'b011_01_0) begin
      n_bad++; $display("FAIL dec_fields: syn=%b err=%b perr=%b want 011 01 0", rsp_syndrome, rsp_err, rsp_proto_err);
    end
    complete0();
  endtask

  task automatic test_hold();
    int bad_cyc = 0;
    m0_b0 = 8'h33; m0_b1 = 8'hE4;
    request0(1'b1, 8'h21);
    req_valid = 1'b1; req_mode = 1'b0; req_data = 8'h01;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_byte0 !== 8'h33 || rsp_byte1 !== 8'hE4 ||
          req_ready !== 1'b0 || pin_out !== 8'h00) bad_cyc++;
    end
    n_cmp++;
    if (bad_cyc !== 0) begin n_bad++; $display("FAIL hold_stable: %0d unstable cycles want 0", bad_cyc); end
    n_cmp++;
    if ({rsp_syndrome, rsp_err, rsp_proto_err} !== {3'b001, 2'b00, CHK}) begin
      n_bad++; $display("FAIL hold_fields: syn=%b err=%b perr=%b want 001 00 %b", rsp_syndrome, rsp_err, rsp_proto_err, CHK);
    end
    req_valid = 1'b0;
    complete0();
  endtask

  task automatic test_extra_lat();
    int wait_n = 0;
    m3_b0 = 8'hA5; m3_b1 = 8'h3C;
    @(negedge clk);
    x_req_valid = 1'b1; x_req_mode = 1'b0; x_req_data = 8'h05;
    while (x_req_ready !== 1'b1 && wait_n < 30) begin @(negedge clk); wait_n++; end
    @(posedge clk);
    lat = 1;
    #1;
    x_req_valid = 1'b0;
    while (x_rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); lat++; #1; end
    n_cmp++;
    if (lat !== 10) begin n_bad++; $display("FAIL lat3_latency: %0d want 10", lat); end
    n_cmp++;
    if ({x_rsp_byte0, x_rsp_byte1, x_rsp_syndrome, x_rsp_err} !== {16'hA53C, 5'b0}) begin
      n_bad++; $display("FAIL lat3_rsp: b0=%h b1=%h syn=%b err=%b want a5 3c 000 00",
                        x_rsp_byte0, x_rsp_byte1, x_rsp_syndrome, x_rsp_err);
    end
    n_cmp++;
    if (x_rsp_proto_err !== CHK) begin n_bad++; $display("FAIL lat3_proto: %b want %b", x_rsp_proto_err, CHK); end
    x_rsp_ready = 1'b1;
    @(posedge clk); #1;
    x_rsp_ready = 1'b0;
    n_cmp++;
    if (x_req_ready !== 1'b1) begin n_bad++; $display("FAIL lat3_idle: req_ready=%b want 1", x_req_ready); end
  endtask

  task automatic test_reset_mid();
    int n = 0, seen_valid = 0, wait_n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_mode = 1'b1; req_data = 8'h3C;
    while (req_ready !== 1'b1 && wait_n < 30) begin @(negedge clk); wait_n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    n_cmp++;
    if (pin_out !== 8'h01) begin n_bad++; $display("FAIL mid_mode_pin: %h want 01", pin_out); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pin_out !== 8'h00) begin n_bad++; $display("FAIL mid_async_pin: %h want 00", pin_out); end
    @(negedge clk);
    rst_n = 1'b1;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); n++; #1;
      if (rsp_valid === 1'b1) seen_valid++;
    end
    n_cmp++;
    if (seen_valid !== 0 || n !== 5) begin
      n_bad++; $display("FAIL mid_flush: valid_cycles=%0d flush=%0d want 0 and 5", seen_valid, n);
    end
    m0_b0 = 8'h5A; m0_b1 = 8'h5B;
    request0(1'b0, 8'h0B);
    n_cmp++;
    if ({rsp_byte0, rsp_byte1, rsp_syndrome, rsp_err} !== {16'h5A5B, 5'b0} || lat !== 7) begin
      n_bad++; $display("FAIL mid_next_rsp: b0=%h b1=%h syn=%b err=%b lat=%0d want 5a 5b 000 00 7",
                        rsp_byte0, rsp_byte1, rsp_syndrome, rsp_err, lat);
    end
    n_cmp++;
    if (rsp_proto_err !== CHK) begin n_bad++; $display("FAIL mid_proto: %b want %b", rsp_proto_err, CHK); end
    complete0();
  endtask

  initial begin
    test_reset();
    test_encode();
    test_decode();
    test_hold();
    test_extra_lat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
